md5_pad_feeder: RTL
===================

Name: md5_pad_feeder

Overview:
- Producer side of the md5sum message interface.
- Accepts an arbitrary-length byte message as a stream of 32-bit words and applies MD5 padding: a 0x80 byte, zero fill, then the 64-bit bit-length.
- Drives md5sum's msg/write_en/rdy handshake one 16-word block at a time and waits for its done pulse between blocks.
- Issues a one-cycle core reset at each message start, so md5sum's chaining registers return to the MD5 IV.

Parameters:
- LEN_W, 64: width of the bit-length counter. Counter wraps mod 2^LEN_W. Bits above LEN_W in the length field are driven 0. Legal range 32..64.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  pulse; begin a new message (honoured only in IDLE)
- s_data  in  32  message word, little-endian packing: byte0 = bits[7:0]
- s_valid  in  1  s_data valid
- s_last  in  1  final word of message
- s_nbytes  in  3  valid bytes in the last word, 0..4; sampled only with s_last; 0 = empty word (empty message or exact-fit end)
- s_ready  out  1  word accepted when s_valid & s_ready
- core_rst_n  out  1  reset to md5sum = rst_n & ~clr_pulse
- core_msg  out  32  to md5sum msg
- core_wen  out  1  to md5sum write_en
- core_rdy  in  1  from md5sum rdy
- core_done  in  1  from md5sum done
- busy  out  1  high from start accept until msg_done
- msg_done  out  1  one-cycle pulse; the digest on md5sum a..d is final

Behaviour:
- Reset values: state IDLE, s_ready 0, core_wen 0, core_msg 0, busy 0, msg_done 0, core_rst_n 0 while rst_n is low.
- Word transfer to the core: occurs on any cycle with core_wen & core_rdy. core_wen is asserted only when core_rdy is high. core_msg is held stable while core_wen is high. core_rdy depends only on core state, so a combinational core_wen = pending & core_rdy is legal.
- Word index widx: 4 bits, 0..15. It increments on each transfer. After the transfer at widx 15, the feeder enters WAIT_DONE and widx wraps to 0.
- Length counter len: cleared in CLR. Adds 32 per non-last accepted word and 8*s_nbytes for the last word.
- IDLE: on start, go to CLR and set busy. start is ignored in every other state.
- CLR: one cycle; core_rst_n = 0. Then go to DATA.
- DATA:
  - s_ready = core_rdy.
  - A non-last word passes straight through as core_msg.
  - On s_last with s_nbytes = n < 4: send s_data with byte n forced to 0x80 and higher bytes forced to 0; set pad_done.
  - On s_last with n = 4: send the word unchanged; pad_done stays 0.
  - Either way, next state is PAD.
- PAD: per cycle, word = 0x00000080 if !pad_done (then set pad_done), else 0.
  - Length placement is legal only when pad_done is set.
  - When widx reaches 14 with pad_done set, go to LEN_LO.
  - If pad_done is set at widx 14 or 15 before length placement was possible, zero-fill through widx 15. Go to WAIT_DONE, then start a new PAD block.
- LEN_LO: core_msg = len[31:0].
- LEN_HI: core_msg = len[63:32], zero-extended. Go to WAIT_DONE with a final flag set.
- WAIT_DONE:
  - core_wen = 0, s_ready = 0.
  - On core_done: if final, go to FIN; else return to the state owning the next block (DATA or PAD).
- FIN: pulse msg_done, clear busy, go to IDLE.
- Simultaneous start and msg_done in FIN: start is ignored.
- s_valid outside DATA: ignored (s_ready = 0).
- rst_n low mid-message: abort to IDLE. core_rst_n is also low, so the core is cleared.

Optional Feature:
- MD5_FEED_BYTESWAP_EN
- Defined: s_data is big-endian packed (byte0 = bits[31:24]) and is byte-reversed before padding and length logic. s_nbytes counts from the MSB end.
- Undefined: s_data is used as-is, little-endian.
- Length words are never swapped.

Test Plan:
- "abc": s_data 0x00636261, s_last, s_nbytes 3 -> words 0x80636261, 13×0, 0x00000018, 0 -> msg_done; a=0x98500190 b=0xb04fd23c c=0x7d3f96d6 d=0x727fe128.
- Empty message: s_last, s_nbytes 0 -> word0 0x00000080, zeros, len 0 -> a=0xd98c1dd4 b=0x04b2008f c=0x980980e9 d=0x7e42f8ec.
- 56 bytes (14 words, last nbytes 4) -> block1 word14 0x80, word15 0. Block2 is all zeros except word14 = 0x000001C0. Exactly 2 core_done pulses before msg_done.
- 64 bytes -> block2 word0 = 0x00000080, word14 = 0x00000200.
- Upstream stall (s_valid toggled every other cycle) -> no core_wen while !core_rdy; digest identical to the unstalled run. Second message after msg_done gives the correct digest, which proves core_rst_n clears the core.
- rst_n low during block 1 of a 64-byte message -> IDLE, busy 0; a new "abc" message then yields the correct digest.

Source files
------------

// File: rtl/md5_pad_feeder_if.sv
// Upstream message-word stream into md5_pad_feeder (valid/ready, last word carries a byte count).
interface md5_pad_feeder_if;
   logic [31:0] s_data;
   logic        s_valid;
   logic        s_last;
   logic [2:0]  s_nbytes;
   logic        s_ready;

   modport master (output s_data, s_valid, s_last, s_nbytes, input s_ready);
   modport slave  (input s_data, s_valid, s_last, s_nbytes, output s_ready);
endinterface

// File: rtl/md5_pad_feeder.sv
// MD5 padding feeder: streams 32-bit message words into md5sum one 16-word block at a time.
// Latency: words pass through combinationally; s_ready follows core_rdy in DATA, blocks end in WAIT_DONE.
// MD5_FEED_BYTESWAP_EN: when defined, s_data is big-endian packed and byte-reversed on entry.
module md5_pad_feeder #(
   parameter int LEN_W = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   md5_pad_feeder_if.slave   s,
   output logic              core_rst_n,
   output logic [31:0]       core_msg,
   output logic              core_wen,
   input  logic              core_rdy,
   input  logic              core_done,
   output logic              busy,
   output logic              msg_done
);

   typedef enum logic [2:0] {
      IDLE, CLR, DATA, PAD, LEN_LO, LEN_HI, WAIT_DONE, FIN
   } state_t;

   state_t           state;
   logic [3:0]       widx;
   logic [LEN_W-1:0] len;
   logic [63:0]      len_ext;
   logic             pad_done;
   logic             final_blk;
   logic             blk_pad;

   logic [31:0]      din;
   logic [31:0]      last_word;
   logic [2:0]       nb_eff;
   logic             pad_hold;
   logic             xfer;

`ifdef MD5_FEED_BYTESWAP_EN
   assign din = {s.s_data[7:0], s.s_data[15:8], s.s_data[23:16], s.s_data[31:24]};
`else
   assign din = s.s_data;
`endif

   assign nb_eff = (s.s_nbytes > 3'd4) ? 3'd4 : s.s_nbytes;

   generate
      if (LEN_W < 64) begin : g_len_pad
         assign len_ext = {{(64-LEN_W){1'b0}}, len};
      end else begin : g_len_full
         assign len_ext = len[63:0];
      end
   endgenerate

   // Short last word: keep bytes below n, 0x80 at byte n, zero above.
   always_comb begin
      last_word = din;
      if (nb_eff < 3'd4) begin
         for (int i = 0; i < 4; i++) begin
            if (i == int'(nb_eff))
               last_word[8*i +: 8] = 8'h80;
            else if (i > int'(nb_eff))
               last_word[8*i +: 8] = 8'h00;
         end
      end
   end

   // Slot 14 with the 0x80 already placed belongs to the length words.
   assign pad_hold = pad_done && (widx == 4'd14);

   always_comb begin
      s.s_ready = 1'b0;
      core_wen  = 1'b0;
      core_msg  = 32'h0;
      unique case (state)
         DATA: begin
            s.s_ready = core_rdy;
            core_wen  = s.s_valid & core_rdy;
            core_msg  = s.s_last ? last_word : din;
         end
         PAD: begin
            core_wen = core_rdy & ~pad_hold;
            core_msg = pad_done ? 32'h0 : 32'h0000_0080;
         end
         LEN_LO: begin
            core_wen = core_rdy;
            core_msg = len_ext[31:0];
         end
         LEN_HI: begin
            core_wen = core_rdy;
            core_msg = len_ext[63:32];
         end
         default: ;
      endcase
   end

   assign xfer       = core_wen & core_rdy;
   assign core_rst_n = rst_n & (state != CLR);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         widx      <= 4'd0;
         len       <= '0;
         pad_done  <= 1'b0;
         final_blk <= 1'b0;
         blk_pad   <= 1'b0;
         busy      <= 1'b0;
         msg_done  <= 1'b0;
      end else begin
         msg_done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  state <= CLR;
                  busy  <= 1'b1;
               end
            end
            CLR: begin
               widx      <= 4'd0;
               len       <= '0;
               pad_done  <= 1'b0;
               final_blk <= 1'b0;
               blk_pad   <= 1'b0;
               state     <= DATA;
            end
            DATA: begin
               if (xfer) begin
                  widx <= widx + 4'd1;
                  if (s.s_last) begin
                     len      <= len + LEN_W'({nb_eff, 3'b000});
                     pad_done <= (nb_eff != 3'd4);
                  end else begin
                     len <= len + LEN_W'(32);
                  end
                  if (widx == 4'd15) begin
                     state   <= WAIT_DONE;
                     blk_pad <= s.s_last;
                  end else if (s.s_last) begin
                     state <= PAD;
                  end
               end
            end
            PAD: begin
               if (pad_hold) begin
                  state <= LEN_LO;
               end else if (xfer) begin
                  pad_done <= 1'b1;
                  widx     <= widx + 4'd1;
                  if (widx == 4'd15) begin
                     state   <= WAIT_DONE;
                     blk_pad <= 1'b1;
                  end
               end
            end
            LEN_LO: begin
               if (xfer) begin
                  widx  <= widx + 4'd1;
                  state <= LEN_HI;
               end
            end
            LEN_HI: begin
               if (xfer) begin
                  widx      <= widx + 4'd1;
                  final_blk <= 1'b1;
                  state     <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               if (core_done) begin
                  if (final_blk) begin
                     state    <= FIN;
                     msg_done <= 1'b1;
                  end else begin
                     state <= blk_pad ? PAD : DATA;
                  end
               end
            end
            FIN: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
